// File: rtl/hazard_scoreboard.sv
// E/M/W writer scoreboard for D/E operand interlock and forwarding, plus the HI/LO busy counter.
// Outputs are combinational from stage state and D inputs; stall holds PC/D while flush_e bubbles E.
module hazard_scoreboard #(
  parameter int NSRC     = 2,
  parameter int AW       = 5,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NSRC*AW-1:0] d_src_addr,
  input  logic [NSRC*2-1:0]  d_src_tuse,
  input  logic               d_dst_we,
  input  logic [AW-1:0]      d_dst_addr,
  input  logic [1:0]         d_dst_tnew,
  input  logic               d_md_use,
  input  logic               d_md_start,
  input  logic               d_md_is_div,
  input  logic               exc_flush,
  output logic               stall,
  output logic               flush_e,
  output logic [NSRC*2-1:0]  fwd_d,
  output logic [NSRC*2-1:0]  fwd_e,
  output logic               md_busy
);

  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW     = $clog2(MD_MAX + 1);
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    tnew;
  } stage_t;

  stage_t             e_q, m_q, w_q, d_entry;
  logic [NSRC*AW-1:0] e_src_addr_q;
  logic [NSRC*2-1:0]  e_src_tuse_q;
  logic [CW-1:0]      md_cnt_q;
  logic [NSRC-1:0]    src_stall;
  logic               md_stall;
  logic               issue;

  logic [AW-1:0] d_addr [NSRC];
  logic [1:0]    d_tuse [NSRC];
  logic [AW-1:0] e_addr [NSRC];
  logic [1:0]    e_tuse [NSRC];

  for (genvar g = 0; g < NSRC; g++) begin : g_unpack
    assign d_addr[g] = d_src_addr[g*AW +: AW];
    assign d_tuse[g] = d_src_tuse[g*2 +: 2];
    assign e_addr[g] = e_src_addr_q[g*AW +: AW];
    assign e_tuse[g] = e_src_tuse_q[g*2 +: 2];
  end

  function automatic stage_t age(input stage_t s);
    stage_t r;
    r      = s;
    r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
    return r;
  endfunction

  function automatic logic hit(input stage_t s, input logic [AW-1:0] a);
    return s.we && (s.addr == a);
  endfunction

  function automatic logic [1:0] sel_if_ready(input logic [1:0] tnew, input logic [1:0] code);
    return (tnew == 2'd0) ? code : 2'b00;
  endfunction

  // Nearest stage wins; a producer still computing stalls only if it is late for this operand.
  always_comb begin
    src_stall = '0;
    fwd_d     = '0;
    fwd_e     = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (d_tuse[i] != TUSE_NONE && d_addr[i] != '0) begin
        if (hit(e_q, d_addr[i])) begin
          src_stall[i]    = e_q.tnew > d_tuse[i];
          fwd_d[i*2 +: 2] = sel_if_ready(e_q.tnew, 2'b01);
        end else if (hit(m_q, d_addr[i])) begin
          src_stall[i]    = m_q.tnew > d_tuse[i];
          fwd_d[i*2 +: 2] = sel_if_ready(m_q.tnew, 2'b10);
        end else if (hit(w_q, d_addr[i])) begin
          src_stall[i]    = w_q.tnew > d_tuse[i];
          fwd_d[i*2 +: 2] = sel_if_ready(w_q.tnew, 2'b11);
        end
      end
      if (e_tuse[i] != TUSE_NONE && e_addr[i] != '0) begin
        if (hit(m_q, e_addr[i]) && m_q.tnew == 2'd0) begin
          fwd_e[i*2 +: 2] = 2'b10;
        end else if (hit(w_q, e_addr[i])) begin
          fwd_e[i*2 +: 2] = 2'b11;
        end
      end
    end
  end

  always_comb begin
    d_entry.we   = d_dst_we && (d_dst_addr != '0);
    d_entry.addr = d_dst_addr;
    d_entry.tnew = d_dst_tnew;
  end

  assign md_stall = d_md_use && (md_cnt_q != '0);
  assign stall    = !exc_flush && ((|src_stall) || md_stall);
  assign flush_e  = stall || exc_flush;
  assign issue    = !stall && !exc_flush;
  assign md_busy  = (md_cnt_q != '0);

  // An issued MULT/DIV cannot be cancelled, so exc_flush leaves md_cnt_q counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q          <= '0;
      m_q          <= '0;
      w_q          <= '0;
      e_src_addr_q <= '0;
      e_src_tuse_q <= '1;
      md_cnt_q     <= '0;
    end else begin
      w_q          <= age(m_q);
      m_q          <= exc_flush ? stage_t'('0) : age(e_q);
      e_q          <= issue ? d_entry : stage_t'('0);
      e_src_addr_q <= issue ? d_src_addr : '0;
      e_src_tuse_q <= issue ? d_src_tuse : '1;
      if (issue && d_md_start) begin
        md_cnt_q <= d_md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (md_cnt_q != '0) begin
        md_cnt_q <= md_cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random check of hazard_scoreboard against a model that keeps, per cycle,
// the instruction that entered E and derives stage age and remaining Tnew arithmetically.
module tb_hazard_scoreboard;
  localparam int NSRC = 2, AW = 5, MULT_CYC = 5, DIV_CYC = 10, MAXC = 4096;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NSRC*AW-1:0] d_src_addr;
  logic [NSRC*2-1:0]  d_src_tuse;
  logic               d_dst_we;
  logic [AW-1:0]      d_dst_addr;
  logic [1:0]         d_dst_tnew;
  logic               d_md_use, d_md_start, d_md_is_div, exc_flush;
  logic               stall, flush_e, md_busy;
  logic [NSRC*2-1:0]  fwd_d, fwd_e;

  hazard_scoreboard #(.NSRC(NSRC), .AW(AW), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .d_src_addr(d_src_addr), .d_src_tuse(d_src_tuse),
    .d_dst_we(d_dst_we), .d_dst_addr(d_dst_addr), .d_dst_tnew(d_dst_tnew),
    .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
    .exc_flush(exc_flush), .stall(stall), .flush_e(flush_e), .fwd_d(fwd_d),
    .fwd_e(fwd_e), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc, rst_cyc, md_free;
  bit h_v [MAXC];
  bit h_kill [MAXC];
  bit h_we [MAXC];
  int h_dst [MAXC];
  int h_tnew [MAXC];
  int h_src [MAXC][NSRC];
  int h_tu [MAXC][NSRC];
  bit exp_raw, exp_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  // History index of the instruction in stage age (0=E,1=M,2=W) this cycle, or -1 if none.
  function automatic int sidx(input int a);
    int idx;
    idx = cyc - a;
    if (idx <= rst_cyc) return -1;
    if (!h_v[idx]) return -1;
    if (a > 0 && h_kill[idx]) return -1;
    return idx;
  endfunction

  task automatic drive(input int s0, t0, s1, t1, input bit we, input int dst, tn,
                       input bit mu, ms, mdiv, ex);
    logic [NSRC*2-1:0] efd, efe;
    int sa [NSRC];
    int st [NSRC];
    sa[0] = s0; sa[1] = s1; st[0] = t0; st[1] = t1;
    d_src_addr = {AW'(s1), AW'(s0)};
    d_src_tuse = {2'(t1), 2'(t0)};
    d_dst_we = we; d_dst_addr = AW'(dst); d_dst_tnew = 2'(tn);
    d_md_use = mu; d_md_start = ms; d_md_is_div = mdiv; exc_flush = ex;
    #1;
    exp_raw = 1'b0; efd = '0; efe = '0;
    for (int i = 0; i < NSRC; i++) begin
      bit found;
      int ix, rem, ie, im, iw, ea, et;
      found = 1'b0;
      if (st[i] != 3 && sa[i] != 0) begin
        for (int a = 0; a < 3; a++) begin
          ix = sidx(a);
          if (!found && ix >= 0 && h_we[ix] && h_dst[ix] == sa[i]) begin
            rem = h_tnew[ix] - a;
            if (rem < 0) rem = 0;
            if (rem > st[i]) exp_raw = 1'b1;
            if (rem == 0) efd[i*2 +: 2] = 2'(a + 1);
            found = 1'b1;
          end
        end
      end
      ie = sidx(0);
      if (ie >= 0) begin
        ea = h_src[ie][i]; et = h_tu[ie][i];
        im = sidx(1); iw = sidx(2);
        if (et != 3 && ea != 0) begin
          if (im >= 0 && h_we[im] && h_dst[im] == ea && h_tnew[im] <= 1) efe[i*2 +: 2] = 2'b10;
          else if (iw >= 0 && h_we[iw] && h_dst[iw] == ea) efe[i*2 +: 2] = 2'b11;
        end
      end
    end
    if (mu && cyc < md_free) exp_raw = 1'b1;
    exp_stall = exp_raw && !ex;
    chk("stall", stall, exp_stall);
    chk("flush_e", flush_e, exp_stall || ex);
    chk("md_busy", md_busy, cyc < md_free);
    chk("fwd_e", fwd_e, efe);
    if (!exp_raw) chk("fwd_d", fwd_d, efd);
  endtask

  task automatic tick();
    bit iss;
    iss = !exp_stall && !exc_flush;
    @(posedge clk);
    h_v[cyc+1] = iss; h_kill[cyc+1] = 1'b0;
    h_we[cyc+1] = d_dst_we; h_dst[cyc+1] = int'(d_dst_addr); h_tnew[cyc+1] = int'(d_dst_tnew);
    for (int i = 0; i < NSRC; i++) begin
      h_src[cyc+1][i] = int'(d_src_addr[i*AW +: AW]);
      h_tu[cyc+1][i]  = int'(d_src_tuse[i*2 +: 2]);
    end
    if (exc_flush) h_kill[cyc] = 1'b1;
    if (iss && d_md_start) md_free = cyc + 1 + (d_md_is_div ? DIV_CYC : MULT_CYC);
    cyc++;
    @(negedge clk);
  endtask

  task automatic nop();
    drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_flush_e", flush_e, 0);
    chk("rst_fwd_d", fwd_d, 0);
    chk("rst_fwd_e", fwd_e, 0);
    chk("rst_md_busy", md_busy, 0);
    @(negedge clk);
    rst_cyc = cyc;
    md_free = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b;
    reset_n = 1'b0; d_src_addr = '0; d_src_tuse = '1; d_dst_we = 0; d_dst_addr = '0;
    d_dst_tnew = '0; d_md_use = 0; d_md_start = 0; d_md_is_div = 0; exc_flush = 0;
    cyc = 5; rst_cyc = 5; md_free = 0; exp_stall = 0; exp_raw = 0;
    do_reset();

    // load $3 then ALU on $3
    drive(0, 3, 0, 3, 1, 3, 2, 0, 0, 0, 0); tick();
    drive(3, 1, 0, 3, 1, 4, 1, 0, 0, 0, 0);
    chk("lu_stall", stall, 1); chk("lu_flush_e", flush_e, 1); tick();
    drive(3, 1, 0, 3, 1, 4, 1, 0, 0, 0, 0);
    chk("lu_issue", stall, 0); chk("lu_fwd_d", fwd_d[1:0], 2'b00); tick();
    drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_e_w", fwd_e[1:0], 2'b11); tick();
    nop(); nop();

    // ALU $5 then branch on $5
    drive(0, 3, 0, 3, 1, 5, 1, 0, 0, 0, 0); tick();
    drive(5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0); chk("ab_stall", stall, 1); tick();
    drive(5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("ab_issue", stall, 0); chk("ab_fwd_m", fwd_d[1:0], 2'b10); tick();
    nop(); nop();

    // load $6 then branch on $6: two stalls, then W forward
    drive(0, 3, 0, 3, 1, 6, 2, 0, 0, 0, 0); tick();
    n = 0;
    drive(6, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    while (stall && n < 20) begin n++; tick(); drive(6, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0); end
    chk("lb_stall_cycles", n, 2); chk("lb_fwd_w", fwd_d[1:0], 2'b11); tick();
    nop(); nop();

    // load $8 then store with data $8: never stalls
    drive(0, 3, 0, 3, 1, 8, 2, 0, 0, 0, 0); tick();
    drive(2, 1, 8, 2, 0, 0, 0, 0, 0, 0, 0); chk("ls_no_stall", stall, 0); tick();
    nop(); nop(); nop();

    // back-to-back writers of $7: nearest stage wins
    drive(0, 3, 0, 3, 1, 7, 1, 0, 0, 0, 0); tick();
    drive(0, 3, 0, 3, 1, 7, 0, 0, 0, 0, 0); tick();
    drive(7, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("bb_e_stall", stall, 0); chk("bb_fwd_e", fwd_d[1:0], 2'b01); tick();
    nop(); nop(); nop();
    drive(0, 3, 0, 3, 1, 7, 1, 0, 0, 0, 0); tick();
    drive(0, 3, 0, 3, 1, 7, 1, 0, 0, 0, 0); tick();
    drive(0, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0); chk("bb_stall", stall, 1); tick();
    drive(0, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bb_m_over_w", fwd_d[3:2], 2'b10); tick();
    nop(); nop(); nop();

    // writes to $0 are invisible
    drive(0, 3, 0, 3, 1, 0, 2, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_stall", stall, 0); chk("r0_fwd_d", fwd_d, 0); tick();
    drive(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0); chk("r0_fwd_e", fwd_e, 0); tick();

    // DIV then MFHI, MULT then MFLO
    drive(0, 3, 0, 3, 0, 0, 0, 1, 1, 1, 0); tick();
    n = 0; b = 0;
    drive(0, 3, 0, 3, 1, 9, 1, 1, 0, 0, 0);
    while (stall && n < 30) begin
      n++; if (md_busy) b++;
      tick(); drive(0, 3, 0, 3, 1, 9, 1, 1, 0, 0, 0);
    end
    chk("div_stall_cycles", n, DIV_CYC); chk("div_busy_cycles", b, DIV_CYC);
    chk("div_idle_at_issue", md_busy, 0); tick();
    drive(0, 3, 0, 3, 0, 0, 0, 1, 1, 0, 0); tick();
    n = 0;
    drive(0, 3, 0, 3, 1, 9, 1, 1, 0, 0, 0);
    while (stall && n < 30) begin n++; tick(); drive(0, 3, 0, 3, 1, 9, 1, 1, 0, 0, 0); end
    chk("mult_stall_cycles", n, MULT_CYC); tick();
    nop(); nop();

    // load-use hit by exc_flush while a MULT is running
    drive(0, 3, 0, 3, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(0, 3, 0, 3, 1, 9, 2, 0, 0, 0, 0); tick();
    drive(9, 1, 0, 3, 1, 4, 1, 0, 0, 0, 1);
    chk("xf_stall", stall, 0); chk("xf_flush_e", flush_e, 1); tick();
    drive(9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("xf_bubbles", stall, 0); chk("xf_md_busy", md_busy, 1); tick();
    n = 0;
    drive(0, 3, 0, 3, 0, 0, 0, 1, 0, 0, 0);
    while (stall && n < 30) begin n++; tick(); drive(0, 3, 0, 3, 0, 0, 0, 1, 0, 0, 0); end
    chk("xf_md_kept_counting", n, MULT_CYC - 3); tick();
    nop(); nop();

    // reset in the middle of a load-use stall with a DIV running
    drive(0, 3, 0, 3, 0, 0, 0, 1, 1, 1, 0); tick();
    drive(0, 3, 0, 3, 1, 3, 2, 0, 0, 0, 0); tick();
    drive(3, 1, 0, 3, 1, 4, 1, 0, 0, 0, 0); chk("mr_stall_before", stall, 1);
    do_reset();
    drive(3, 1, 0, 3, 1, 4, 1, 0, 0, 0, 0); chk("mr_no_stale", stall, 0); tick();
    drive(0, 3, 0, 3, 0, 0, 0, 1, 0, 0, 0); chk("mr_div_abandoned", stall, 0); tick();

    for (int k = 0; k < 600; k++) begin
      bit mu, ms;
      ms = ($urandom_range(0, 11) == 0);
      mu = ms || ($urandom_range(0, 7) == 0);
      drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
            mu, ms, bit'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      tick();
      if (k == 300) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
